// File: rtl/iiitb_rc_arb.sv
// Round-robin arbiter for 4 requesters, driven by a one-hot token ring.
// Define RC_ARB_TIMEOUT_EN to force a grant release after HOLD_MAX cycles.
module iiitb_rc_arb #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] init,
  input  logic       load,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [3:0] token,
  output logic       err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    GRANT = 2'b10
  } state_t;

  state_t     state;
  logic       init_onehot;
  logic [3:0] token_rot;
  logic       gnt_held;
  logic       hold_expire;
  logic       release_now;

  assign init_onehot = (init != 4'b0000) && ((init & (init - 4'b0001)) == 4'b0000);
  assign token_rot   = {token[2:0], token[3]};
  assign gnt_held    = |(req & gnt);

`ifdef RC_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign hold_expire = (hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign hold_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign release_now = done | ~gnt_held | hold_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      token     <= 4'b0001;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      err       <= 1'b0;
`ifdef RC_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
      hold_cnt  <= '0;
`endif
    end else begin
`ifdef RC_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (load) begin
            if (init_onehot) begin
              token <= init;
              err   <= 1'b0;
            end else begin
              err   <= 1'b1;
            end
          end else if (|req) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (|(req & token)) begin
            state     <= GRANT;
            gnt       <= token;
            gnt_valid <= 1'b1;
`ifdef RC_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end else if (|req) begin
            token <= token_rot;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
`ifdef RC_ARB_TIMEOUT_EN
          hold_cnt <= hold_cnt + 8'd1;
          // done and a dropped request both outrank the forced release
          timeout  <= ~done & gnt_held & hold_expire;
`endif
          if (release_now) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            token     <= token_rot;
            state     <= (|(req & ~gnt)) ? SCAN : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iiitb_rc_arb.sv
// Directed self-checking bench for iiitb_rc_arb (HOLD_MAX overridden to 4).
module tb_iiitb_rc_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] init;
  logic       load;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [3:0] token;
  logic       err;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  iiitb_rc_arb #(.HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset), .init(init), .load(load), .req(req),
    .done(done), .gnt(gnt), .gnt_valid(gnt_valid), .token(token),
    .err(err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; init = '0; load = 1'b0; req = '0; done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (token !== 4'b0001) begin n_err++; $display("FAIL reset_token: got %b want 0001", token); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL reset_gnt_valid: got %b want 0", gnt_valid); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_load();
    do_reset();
    init = 4'b0010; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (token !== 4'b0010) begin n_err++; $display("FAIL load_legal_token: got %b want 0010", token); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL load_legal_err: got %b want 0", err); end
    init = 4'b0110; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (token !== 4'b0010) begin n_err++; $display("FAIL load_multi_token: got %b want 0010", token); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL load_multi_err: got %b want 1", err); end
    tick(); tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL load_err_sticky: got %b want 1", err); end
    init = 4'b0000; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (token !== 4'b0010) begin n_err++; $display("FAIL load_zero_token: got %b want 0010", token); end
    init = 4'b1000; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (token !== 4'b1000) begin n_err++; $display("FAIL load_relegal_token: got %b want 1000", token); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL load_relegal_err: got %b want 0", err); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_early: got %b want 0000", gnt); end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt_lat2: got %b want 0001", gnt); end
    n_cmp++; if (gnt_valid !== 1'b1) begin n_err++; $display("FAIL single_gnt_valid: got %b want 1", gnt_valid); end
    tick(); tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL single_gnt_held: got %b want 0001", gnt); end
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_release: got %b want 0000", gnt); end
    n_cmp++; if (gnt_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_release: got %b want 0", gnt_valid); end
    n_cmp++; if (token !== 4'b0010) begin n_err++; $display("FAIL single_token_rot: got %b want 0010", token); end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_tok [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    req = 4'b1111; tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (gnt !== exp_gnt[i]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
      done = 1'b1; tick(); done = 1'b0;
      n_cmp++; if (gnt !== 4'b0000 || token !== exp_tok[i]) begin
        n_err++; $display("FAIL rr_release[%0d]: got gnt=%b token=%b want gnt=0000 token=%b", i, gnt, token, exp_tok[i]);
      end
    end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_worst_case();
    do_reset();
    req = 4'b1000; tick();
    tick();
    n_cmp++; if (token !== 4'b0010) begin n_err++; $display("FAIL worst_token1: got %b want 0010", token); end
    init = 4'b0001; load = 1'b1; tick(); load = 1'b0;
    n_cmp++; if (token !== 4'b0100) begin n_err++; $display("FAIL worst_load_ignored: got %b want 0100", token); end
    tick();
    n_cmp++; if (token !== 4'b1000 || gnt !== 4'b0000) begin n_err++; $display("FAIL worst_token3: got token=%b gnt=%b want token=1000 gnt=0000", token, gnt); end
    tick();
    n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL worst_gnt_cycle5: got %b want 1000", gnt); end
    req = 4'b0000; tick();
    n_cmp++; if (gnt !== 4'b0000 || token !== 4'b0001) begin n_err++; $display("FAIL worst_drop: got gnt=%b token=%b want gnt=0000 token=0001", gnt, token); end
    tick();
  endtask

  task automatic test_other_req_then_reset();
    do_reset();
    req = 4'b0001; tick(); tick();
    req = 4'b1111; tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL other_req_1111: got %b want 0001", gnt); end
    req = 4'b0101; tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL other_req_0101: got %b want 0001", gnt); end
    req = 4'b0100; tick();
    n_cmp++; if (gnt !== 4'b0000 || token !== 4'b0010) begin n_err++; $display("FAIL drop_release: got gnt=%b token=%b want gnt=0000 token=0010", gnt, token); end
    tick();
    n_cmp++; if (token !== 4'b0100) begin n_err++; $display("FAIL drop_scan_rot: got %b want 0100", token); end
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL drop_regrant: got %b want 0100", gnt); end
    #2 reset = 1'b1; #1;
    n_cmp++; if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || token !== 4'b0001) begin
      n_err++; $display("FAIL async_reset: got gnt=%b valid=%b token=%b want 0000/0/0001", gnt, gnt_valid, token);
    end
    tick(); reset = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (gnt !== 4'b0000 || token !== 4'b0100) begin n_err++; $display("FAIL post_reset_scan: got gnt=%b token=%b want gnt=0000 token=0100", gnt, token); end
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL post_reset_gnt: got %b want 0100", gnt); end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0001; tick(); tick();
`ifdef RC_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin n_err++; $display("FAIL to_hold[%0d]: got gnt=%b timeout=%b want 0001/0", i, gnt, timeout); end
    end
    tick();
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b1 || token !== 4'b0010) begin
      n_err++; $display("FAIL to_release: got gnt=%b timeout=%b token=%b want 0000/1/0010", gnt, timeout, token);
    end
    tick();
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
    for (int i = 0; i < 8 && gnt !== 4'b0001; i++) tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL to_regrant: got %b want 0001", gnt); end
    tick(); tick(); tick();
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000 || timeout !== 1'b0) begin n_err++; $display("FAIL to_done_wins: got gnt=%b timeout=%b want 0000/0", gnt, timeout); end
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0001 || timeout !== 1'b0) begin n_err++; $display("FAIL hold_forever[%0d]: got gnt=%b timeout=%b want 0001/0", i, gnt, timeout); end
    end
    done = 1'b1; tick(); done = 1'b0;
    n_cmp++; if (gnt !== 4'b0000 || token !== 4'b0010) begin n_err++; $display("FAIL hold_done: got gnt=%b token=%b want 0000/0010", gnt, token); end
`endif
    req = 4'b0000; tick(); tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_round_robin();
    test_worst_case();
    test_other_req_then_reset();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
